// File: rtl/maxpool2x2_relu_16channel.sv
// Streaming 2x2/stride-2 max-pool over 16 packed IEEE-754 channels, with a half-width line buffer.
// Optional ReLU on the pooled result when MAXPOOL2X2_RELU_EN is defined.
module maxpool2x2_relu_16channel #(
    parameter int unsigned DATA_WIDHT = 32,
    parameter int unsigned IMG_WIDHT  = 44,
    parameter int unsigned IMG_HEIGHT = 44
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDHT*16-1:0] Data_In,
    input  logic                     Valid_In,
    output logic [DATA_WIDHT*16-1:0] Data_Out,
    output logic                     Valid_Out,
    output logic                     Frame_Done
);

    localparam int unsigned NumCh   = 16;
    localparam int unsigned PixW    = DATA_WIDHT * NumCh;
    localparam int unsigned LbDepth = IMG_WIDHT / 2;
    localparam int unsigned ColW    = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
    localparam int unsigned RowW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned LbW     = (LbDepth > 1) ? $clog2(LbDepth) : 1;
    // Position of the final pooled window; trailing odd column/row never pairs.
    localparam int unsigned LastCol = (IMG_WIDHT / 2) * 2 - 1;
    localparam int unsigned LastRow = (IMG_HEIGHT / 2) * 2 - 1;

    // Sign-magnitude ordering on raw bits; +0 beats -0 through the sign rule.
    function automatic logic [DATA_WIDHT-1:0] fmax(input logic [DATA_WIDHT-1:0] a,
                                                   input logic [DATA_WIDHT-1:0] b);
        logic [DATA_WIDHT-2:0] ma;
        logic [DATA_WIDHT-2:0] mb;
        ma = a[DATA_WIDHT-2:0];
        mb = b[DATA_WIDHT-2:0];
        if (a[DATA_WIDHT-1] != b[DATA_WIDHT-1]) begin
            fmax = a[DATA_WIDHT-1] ? b : a;
        end else if (!a[DATA_WIDHT-1]) begin
            fmax = (ma >= mb) ? a : b;
        end else begin
            fmax = (ma <= mb) ? a : b;
        end
    endfunction

    logic [ColW-1:0] r_col;
    logic [RowW-1:0] r_row;
    logic [PixW-1:0] r_hold;
    logic [PixW-1:0] r_linebuf [LbDepth];
    logic [PixW-1:0] r_data_out;
    logic            r_valid_out;
    logic            r_frame_done;

    logic [LbW-1:0]  w_lb_idx;
    logic [PixW-1:0] w_hmax;
    logic [PixW-1:0] w_vmax;
    logic [PixW-1:0] w_out;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_final_win;

    assign w_lb_idx    = LbW'(r_col >> 1);
    assign w_col_last  = (r_col == ColW'(IMG_WIDHT - 1));
    assign w_row_last  = (r_row == RowW'(IMG_HEIGHT - 1));
    assign w_final_win = (r_col == ColW'(LastCol)) && (r_row == RowW'(LastRow));

    for (genvar k = 0; k < NumCh; k++) begin : g_ch
        assign w_hmax[k*DATA_WIDHT +: DATA_WIDHT] =
            fmax(r_hold[k*DATA_WIDHT +: DATA_WIDHT], Data_In[k*DATA_WIDHT +: DATA_WIDHT]);
        assign w_vmax[k*DATA_WIDHT +: DATA_WIDHT] =
            fmax(r_linebuf[w_lb_idx][k*DATA_WIDHT +: DATA_WIDHT],
                 w_hmax[k*DATA_WIDHT +: DATA_WIDHT]);
`ifdef MAXPOOL2X2_RELU_EN
        assign w_out[k*DATA_WIDHT +: DATA_WIDHT] =
            w_vmax[(k+1)*DATA_WIDHT-1] ? '0 : w_vmax[k*DATA_WIDHT +: DATA_WIDHT];
`else
        assign w_out[k*DATA_WIDHT +: DATA_WIDHT] = w_vmax[k*DATA_WIDHT +: DATA_WIDHT];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (Valid_In) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (!r_col[0]) begin
                    r_hold <= Data_In;
                end else if (r_row[0]) begin
                    r_data_out   <= w_out;
                    r_valid_out  <= 1'b1;
                    r_frame_done <= w_final_win;
                end
            end
        end
    end

    // Even-row partial maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (Valid_In && r_col[0] && !r_row[0]) begin
            r_linebuf[w_lb_idx] <= w_hmax;
        end
    end

    assign Data_Out   = r_data_out;
    assign Valid_Out  = r_valid_out;
    assign Frame_Done = r_frame_done;

endmodule

// File: tb/tb_maxpool2x2_relu_16channel.sv
// Bench for maxpool2x2_relu_16channel: a 44x44 and a 5x5 instance driven by the same stream,
// each checked every cycle against a frame-array reference model.
module tb_maxpool2x2_relu_16channel;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] Data_In = '0;
    logic         Valid_In = 1'b0;
    logic [511:0] Data_Out, Data_Out_s;
    logic         Valid_Out, Valid_Out_s;
    logic         Frame_Done, Frame_Done_s;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    int n_fd     = 0;

    always #5 clk = ~clk;

    maxpool2x2_relu_16channel #(.DATA_WIDHT(32), .IMG_WIDHT(44), .IMG_HEIGHT(44)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .Data_In    (Data_In),
        .Valid_In   (Valid_In),
        .Data_Out   (Data_Out),
        .Valid_Out  (Valid_Out),
        .Frame_Done (Frame_Done)
    );

    maxpool2x2_relu_16channel #(.DATA_WIDHT(32), .IMG_WIDHT(5), .IMG_HEIGHT(5)) u_dut_s (
        .clk        (clk),
        .rst        (rst),
        .Data_In    (Data_In),
        .Valid_In   (Valid_In),
        .Data_Out   (Data_Out_s),
        .Valid_Out  (Valid_Out_s),
        .Frame_Done (Frame_Done_s)
    );

    // Reference model state, index 0 = 44x44, index 1 = 5x5.
    logic [511:0] m_img [2][44][44];
    int           m_col [2];
    int           m_row [2];
    logic [511:0] m_dout [2];
    logic         m_v [2];
    logic         m_fd [2];

    function automatic int dim_of(input int d);
        return (d == 0) ? 44 : 5;
    endfunction

    // Map float bits onto a signed total order: negatives below all positives, -0 just below +0.
    function automatic longint fkey(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? (-mag - 1) : mag;
    endfunction

    function automatic logic [31:0] fmax_ref(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    function automatic logic [511:0] pool(input int d, input int r, input int c);
        logic [511:0] res;
        logic [31:0]  m;
        for (int k = 0; k < 16; k++) begin
            m = fmax_ref(fmax_ref(m_img[d][r-1][c-1][32*k +: 32], m_img[d][r-1][c][32*k +: 32]),
                         fmax_ref(m_img[d][r][c-1][32*k +: 32], m_img[d][r][c][32*k +: 32]));
`ifdef MAXPOOL2X2_RELU_EN
            if (m[31]) m = 32'h0;
`endif
            res[32*k +: 32] = m;
        end
        return res;
    endfunction

    function automatic logic [31:0] i2f(input int n);
        int          e;
        logic [31:0] t;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 31; i++) if (((n >> i) & 1) == 1) e = i;
        t = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), t[22:0]};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h3F80_0000;
            3:       return 32'hBF80_0000;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [511:0] rand_pix();
        logic [511:0] p;
        for (int k = 0; k < 16; k++) p[32*k +: 32] = rand_word();
        return p;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_44", 512'(Valid_Out), 512'(m_v[0]));
        chk("fdone_44", 512'(Frame_Done), 512'(m_fd[0]));
        chk("data_44", Data_Out, m_dout[0]);
        chk("valid_5", 512'(Valid_Out_s), 512'(m_v[1]));
        chk("fdone_5", 512'(Frame_Done_s), 512'(m_fd[1]));
        chk("data_5", Data_Out_s, m_dout[1]);
    endtask

    task automatic step(input logic v, input logic [511:0] din);
        int w;
        int r;
        int c;
        Valid_In = v;
        Data_In  = din;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            w = dim_of(d);
            r = m_row[d];
            c = m_col[d];
            m_v[d]  = 1'b0;
            m_fd[d] = 1'b0;
            if (v) begin
                m_img[d][r][c] = din;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    m_v[d]    = 1'b1;
                    m_dout[d] = pool(d, r, c);
                    m_fd[d]   = (r == (w / 2) * 2 - 1) && (c == (w / 2) * 2 - 1);
                end
                m_col[d] = c + 1;
                if (m_col[d] == w) begin
                    m_col[d] = 0;
                    m_row[d] = (r + 1 == w) ? 0 : r + 1;
                end
            end
        end
        #1;
        if (Valid_Out) n_pulse++;
        if (Frame_Done) n_fd++;
        check_outputs();
    endtask

    task automatic do_reset();
        Valid_In = 1'b0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_col[d]  = 0;
            m_row[d]  = 0;
            m_v[d]    = 1'b0;
            m_fd[d]   = 1'b0;
            m_dout[d] = '0;
        end
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs();
    endtask

    task automatic run_frame(input bit counting, input int gap_pct, input int stop_idx);
        n_pulse = 0;
        n_fd    = 0;
        for (int r = 0; r < 44; r++) begin
            for (int c = 0; c < 44; c++) begin
                while ($urandom_range(0, 99) < gap_pct) step(1'b0, rand_pix());
                step(1'b1, counting ? {16{i2f(r * 44 + c)}} : rand_pix());
                if (r * 44 + c == stop_idx) return;
            end
        end
    endtask

    initial begin
        do_reset();

        // Positive window: max is 2.0.
        step(1'b1, {16{32'h3F80_0000}});
        step(1'b1, {16{32'h4000_0000}});
        for (int i = 0; i < 42; i++) step(1'b1, '0);
        step(1'b1, {16{32'hBF80_0000}});
        step(1'b1, {16{32'h3F00_0000}});
        chk("win_pos_valid", 512'(Valid_Out), 512'(1));
        chk("win_pos_ch0", 512'(Data_Out[31:0]), 512'(32'h4000_0000));
        step(1'b0, '0);

        // All-negative window.
        do_reset();
        step(1'b1, {16{32'hBF80_0000}});
        step(1'b1, {16{32'hC000_0000}});
        for (int i = 0; i < 42; i++) step(1'b1, '0);
        step(1'b1, {16{32'hBF00_0000}});
        step(1'b1, {16{32'hC040_0000}});
`ifdef MAXPOOL2X2_RELU_EN
        chk("win_neg_ch0", 512'(Data_Out[31:0]), 512'(32'h0000_0000));
`else
        chk("win_neg_ch0", 512'(Data_Out[31:0]), 512'(32'hBF00_0000));
`endif

        // Counting frame, gap-free.
        do_reset();
        run_frame(1'b1, 0, -1);
        chk("count_pulses", 512'(n_pulse), 512'(484));
        chk("count_fdone", 512'(n_fd), 512'(1));
        chk("count_last_ch15", 512'(Data_Out[511:480]), 512'(i2f(43 * 44 + 43)));

        // Counting frame with ~50% gaps, then random data with gaps.
        run_frame(1'b1, 50, -1);
        chk("gap_pulses", 512'(n_pulse), 512'(484));
        chk("gap_fdone", 512'(n_fd), 512'(1));
        run_frame(1'b0, 50, -1);
        chk("rand_pulses", 512'(n_pulse), 512'(484));

        // Abort mid-frame after (row 7, col 20), then a fresh frame.
        run_frame(1'b0, 0, 7 * 44 + 20);
        do_reset();
        run_frame(1'b0, 20, -1);
        chk("post_rst_pulses", 512'(n_pulse), 512'(484));
        chk("post_rst_fdone", 512'(n_fd), 512'(1));
        for (int i = 0; i < 4; i++) step(1'b0, rand_pix());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_relu_16channel.md
Name: maxpool2x2_relu_16channel

Overview:
- Streaming 2x2/stride-2 max-pool with optional ReLU. Sits directly downstream of the 16-channel depthwise 3x3 separable stage.
- Consumes one raster-order pixel per Valid_In beat, carrying all 16 IEEE-754 single-precision channels in parallel.
- Emits one pooled pixel per 2x2 window, so a 44x44 frame becomes 22x22.
- Uses a half-width line buffer to hold even-row partial maxima. No floating-point IP; comparisons are pure bit logic.

Parameters:
- DATA_WIDHT, 32, bits per channel word (IEEE-754 single; sign at MSB).
- IMG_WIDHT, 44, input pixels per row.
- IMG_HEIGHT, 44, input rows per frame.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Data_In  input  DATA_WIDHT*16  channel k at bits [DATA_WIDHT*(k+1)-1 : DATA_WIDHT*k].
- Valid_In  input  1  Data_In is a valid pixel this cycle.
- Data_Out  output  DATA_WIDHT*16  pooled pixel, same channel packing.
- Valid_Out  output  1  one-cycle pulse per pooled pixel.
- Frame_Done  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Behaviour:
- Reset (asynchronous, active-high): column counter, row counter, horizontal-hold register, Data_Out, Valid_Out and Frame_Done all go to 0. Line-buffer contents are don't-care.
- Counters: col 0..IMG_WIDHT-1 and row 0..IMG_HEIGHT-1 advance only on Valid_In.
  - col wraps to 0 at IMG_WIDHT-1 and row increments.
  - At (IMG_WIDHT-1, IMG_HEIGHT-1) both wrap to 0 and the next frame starts without a gap.
- Gaps: Valid_In may deassert on any cycle. All state holds, and there is no timeout.
- Float max, per channel:
  - Signs differ: the operand with sign 0 wins.
  - Both sign 0: larger unsigned value of bits [30:0] wins.
  - Both sign 1: smaller unsigned value of bits [30:0] wins.
  - Equal bit patterns: either operand (identical result).
  - +0 vs -0: +0 wins.
  - NaN/Inf are compared as ordinary bit patterns.
- Even col (col[0]=0): latch Data_In into the hold register.
- Odd col: h = max(hold, Data_In).
  - Even row: write h to line buffer entry col>>1 (depth IMG_WIDHT/2, width DATA_WIDHT*16).
  - Odd row: out = max(linebuf[col>>1], h).
- Output timing: Data_Out is registered. Valid_Out=1 on the cycle after the accepting edge of the odd-row, odd-col beat, i.e. latency 1 cycle. Otherwise Valid_Out=0, and Data_Out holds its last value.
- Frame_Done: pulses with the Valid_Out for input position (IMG_WIDHT-1 or IMG_WIDHT-2 rounded to odd, IMG_HEIGHT-1 or last odd row), i.e. the final pooled pixel.
- Odd dimensions: a trailing unpaired column or row is consumed by the counters but produces no output (floor semantics).
- Reset mid-frame: output pulses abort immediately, and the next Valid_In beat is treated as (col 0, row 0).
- Throughput: accepts Valid_In every cycle indefinitely; no backpressure port.

Optional Feature:
- Macro MAXPOOL2X2_RELU_EN.
- Defined: each channel of the final max passes through ReLU before the output register. Sign bit 1 → 32'h00000000 (including -0); otherwise unchanged.
- Undefined: raw max is output, so negative values and -0 pass through. Latency and handshake are identical in both builds.

Test Plan:
- Window of one channel: even row 1.0 (3F800000) and 2.0 (40000000); odd row -1.0 (BF800000) and 0.5 (3F000000) → Data_Out ch0 = 40000000, Valid_Out exactly 1 cycle after the 4th beat.
- All-negative window {-1.0, -2.0 (C0000000), -0.5 (BF000000), -3.0 (C0400000)}: MAXPOOL2X2_RELU_EN undefined → BF000000; defined → 00000000.
- Full 44x44 frame with pixel value = row*44+col as float in all 16 channels → 484 Valid_Out pulses. Output (r,c) equals the input at (2r+1, 2c+1). Frame_Done is asserted only on the 484th pulse.
- Random Valid_In gaps (≈50% duty) over a full frame → same 484 outputs in the same order as the gap-free run.
- Assert rst for 1 cycle after row 7 col 20 mid-frame, then send a fresh frame → no Valid_Out during reset, outputs read 0 after reset, and the new frame matches the golden model from (0,0).
- IMG_WIDHT=5, IMG_HEIGHT=5 build → 4 outputs per frame; column 4 and row 4 are ignored, and back-to-back frames stay aligned.
